// File: rtl/p10_pkg_common.sv
// Shared types for the p10 register block: ROM descriptor, access rights,
// response status and the parameter-access FSM states.
package p10_pkg_common;

    localparam int unsigned LIM_W = 24;

    typedef enum logic [1:0] {
        PRM_RO = 2'd0,
        PRM_WO = 2'd1,
        PRM_RW = 2'd2
    } prm_rights_t;

    typedef struct packed {
        prm_rights_t      rights;
        logic             is_exec;
        logic [LIM_W-1:0] min_val;
        logic [LIM_W-1:0] max_val;
    } prm_entry_t;

    typedef enum logic [1:0] {
        OK         = 2'd0,
        ERR_ADDR   = 2'd1,
        ERR_RIGHTS = 2'd2,
        ERR_RANGE  = 2'd3
    } prm_status_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_CHECK = 2'd2,
        ST_RESP  = 2'd3
    } prm_state_t;

endpackage

// File: rtl/p10_prm_check.sv
// Combinational access check: address, then rights, then value range.
module p10_prm_check
    import p10_pkg_common::*;
#(
    parameter int unsigned VAL_W = 32
) (
    input  logic             addr_ok,
    input  logic             wr,
    input  logic [VAL_W-1:0] val,
    input  prm_entry_t       entry,
    output prm_status_t      status_c
);

    logic [VAL_W-1:0] lo_c;
    logic [VAL_W-1:0] hi_c;

    // First failing check wins; the entry is meaningless when the address is out of range.
    always_comb begin
        lo_c     = VAL_W'(entry.min_val);
        hi_c     = VAL_W'(entry.max_val);
        status_c = OK;
        if (!addr_ok) begin
            status_c = ERR_ADDR;
        end else if ((wr && entry.rights == PRM_RO) || (!wr && entry.rights == PRM_WO)) begin
            status_c = ERR_RIGHTS;
        end else if (wr && (val < lo_c || val > hi_c)) begin
            status_c = ERR_RANGE;
        end
    end

endmodule

// File: rtl/p10_prm_access.sv
// Parameter access controller: fetches the ROM descriptor for each request,
// checks it, updates the register file on an OK write and returns a status.
module p10_prm_access
    import p10_pkg_common::*;
#(
    parameter  int unsigned PRM_COUNT = 8,
    parameter  int unsigned VAL_W     = 32,
    localparam int unsigned AW        = $clog2(PRM_COUNT + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_wr,
    input  logic [AW-1:0]              req_addr,
    input  logic [VAL_W-1:0]           req_val,
    output logic [AW-1:0]              rom_addr,
    input  prm_entry_t                 rom_entry,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output prm_status_t                rsp_status,
    output logic [VAL_W-1:0]           rsp_val,
    output logic [PRM_COUNT*VAL_W-1:0] prm_regs,
    output logic [PRM_COUNT-1:0]       exec_pulse
);

    prm_state_t       state;
    prm_state_t       state_d;
    logic             accept_c;
    logic             finish_c;
    logic             done_c;
    logic             wr_q;
    logic [AW-1:0]    addr_q;
    logic [VAL_W-1:0] val_q;
    logic             addr_ok_c;
    logic             wr_ok_c;
    logic [VAL_W-1:0] rd_val_c;
    prm_status_t      status_c;

    assign addr_ok_c = (addr_q < AW'(PRM_COUNT));
    assign wr_ok_c   = finish_c && wr_q && (status_c == OK);

    p10_prm_check #(
        .VAL_W (VAL_W)
    ) u_check (
        .addr_ok  (addr_ok_c),
        .wr       (wr_q),
        .val      (val_q),
        .entry    (rom_entry),
        .status_c (status_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        accept_c = 1'b0;
        finish_c = 1'b0;
        done_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    accept_c = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_CHECK;
            ST_CHECK: begin
                finish_c = 1'b1;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    done_c  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read mux over the flat register file.
    always_comb begin
        rd_val_c = '0;
        for (int i = 0; i < int'(PRM_COUNT); i++) begin
            if (addr_q == AW'(i)) begin
                rd_val_c = prm_regs[i*VAL_W +: VAL_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_status <= OK;
            rsp_val    <= '0;
            rom_addr   <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            val_q      <= '0;
            prm_regs   <= '0;
            exec_pulse <= '0;
        end else begin
            if (accept_c) begin
                wr_q      <= req_wr;
                addr_q    <= req_addr;
                val_q     <= req_val;
                rom_addr  <= (req_addr < AW'(PRM_COUNT)) ? req_addr : '0;
                req_ready <= 1'b0;
            end
            if (finish_c) begin
                rsp_valid  <= 1'b1;
                rsp_status <= status_c;
                rsp_val    <= (status_c != OK) ? '0 : (wr_q ? val_q : rd_val_c);
            end
            if (done_c) begin
                rsp_valid <= 1'b0;
                req_ready <= 1'b1;
            end
            // Pulse is set only on the CHECK exit edge, so it never outlasts the first RESP cycle.
            for (int i = 0; i < int'(PRM_COUNT); i++) begin
                exec_pulse[i] <= wr_ok_c && rom_entry.is_exec && (addr_q == AW'(i));
                if (wr_ok_c && addr_q == AW'(i)) begin
                    prm_regs[i*VAL_W +: VAL_W] <= val_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_p10_prm_access.sv
// Scoreboard bench for p10_prm_access with a registered stub ROM.
module tb_p10_prm_access;
    import p10_pkg_common::*;

    localparam int unsigned N  = 8;
    localparam int unsigned VW = 32;
    localparam int unsigned AW = 4;

    typedef struct {
        prm_status_t st;
        logic [VW-1:0] v;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_wr = 1'b0;
    logic [AW-1:0]     req_addr = '0;
    logic [VW-1:0]     req_val = '0;
    logic [AW-1:0]     rom_addr;
    prm_entry_t        rom_entry = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    prm_status_t       rsp_status;
    logic [VW-1:0]     rsp_val;
    logic [N*VW-1:0]   prm_regs;
    logic [N-1:0]      exec_pulse;

    prm_entry_t        rom_tbl [16];
    logic [VW-1:0]     exp_regs [N];
    exp_t              exp_q [$];
    logic [N-1:0]      prev_exec = '0;
    int                checks = 0;
    int                errors = 0;

    p10_prm_access #(.PRM_COUNT(N), .VAL_W(VW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .req_val    (req_val),
        .rom_addr   (rom_addr),
        .rom_entry  (rom_entry),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_val    (rsp_val),
        .prm_regs   (prm_regs),
        .exec_pulse (exec_pulse)
    );

    always #5 clk = ~clk;

    // Stub ROM: one cycle of read latency.
    always @(posedge clk) rom_entry <= rom_tbl[rom_addr];

    task automatic chk(input string name, input logic [N*VW-1:0] act, input logic [N*VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic prm_entry_t mk(input prm_rights_t r, input logic e,
                                      input logic [LIM_W-1:0] lo, input logic [LIM_W-1:0] hi);
        prm_entry_t x;
        x.rights  = r;
        x.is_exec = e;
        x.min_val = lo;
        x.max_val = hi;
        return x;
    endfunction

    function automatic logic [N*VW-1:0] model_flat();
        logic [N*VW-1:0] f;
        f = '0;
        for (int i = 0; i < int'(N); i++) f[i*VW +: VW] = exp_regs[i];
        return f;
    endfunction

    // Monitor: pops the scoreboard on every response handshake, polices pulse width.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_exec = '0;
        end else begin
            if (exec_pulse != '0 || prev_exec != '0)
                chk("exec_width", N*VW'(exec_pulse & prev_exec), '0);
            prev_exec = exec_pulse;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got status %0d val %0h, none expected", rsp_status, rsp_val);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_status", N*VW'(rsp_status), N*VW'(e.st));
                    chk("rsp_val", N*VW'(rsp_val), N*VW'(e.v));
                end
            end
        end
    end

    task automatic push_exp(input prm_status_t st, input logic [VW-1:0] v);
        exp_t e;
        e.st = st;
        e.v  = v;
        exp_q.push_back(e);
    endtask

    // Called right after the accept edge; returns at the first rsp_valid cycle.
    task automatic wait_rsp(input logic [AW-1:0] exp_rom, input logic [N-1:0] exp_exec);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                chk("rom_addr", N*VW'(rom_addr), N*VW'(exp_rom));
                chk("req_ready_busy", N*VW'(req_ready), '0);
            end
            if (!rsp_valid) chk("exec_early", N*VW'(exec_pulse), '0);
        end while (!rsp_valid && k < 10);
        chk("latency", N*VW'(k), N*VW'(3));
        chk("exec_pulse", N*VW'(exec_pulse), N*VW'(exp_exec));
        chk("prm_regs", prm_regs, model_flat());
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [VW-1:0] val,
                         input prm_status_t st, input logic [VW-1:0] rv, input logic [N-1:0] ex);
        logic [AW-1:0] ra;
        ra = (addr < AW'(N)) ? addr : '0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_val   = val;
        @(negedge clk);
        chk("req_ready_idle", N*VW'(req_ready), N*VW'(1));
        push_exp(st, rv);
        if (wr && st == OK) exp_regs[addr[2:0]] = val;
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(ra, ex);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) rom_tbl[i] = mk(PRM_RW, 1'b0, 24'd0, 24'hFFFFFF);
        rom_tbl[0] = mk(PRM_RW, 1'b0, 24'd0,  24'd500000);
        rom_tbl[1] = mk(PRM_RW, 1'b0, 24'd0,  24'd50);
        rom_tbl[2] = mk(PRM_RO, 1'b1, 24'd0,  24'd100);
        rom_tbl[3] = mk(PRM_RW, 1'b0, 24'd0,  24'd1000);
        rom_tbl[4] = mk(PRM_RW, 1'b1, 24'd0,  24'd1000);
        rom_tbl[5] = mk(PRM_WO, 1'b0, 24'd0,  24'd1000);
        rom_tbl[6] = mk(PRM_RW, 1'b0, 24'd10, 24'd20);
        for (int i = 0; i < int'(N); i++) exp_regs[i] = '0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", N*VW'(req_ready), N*VW'(1));
        chk("rst_rsp_valid", N*VW'(rsp_valid), '0);
        chk("rst_rsp_status", N*VW'(rsp_status), N*VW'(OK));
        chk("rst_rsp_val", N*VW'(rsp_val), '0);
        chk("rst_rom_addr", N*VW'(rom_addr), '0);
        chk("rst_regs", prm_regs, '0);
        chk("rst_exec", N*VW'(exec_pulse), '0);
        rst_n = 1'b1;

        issue(1'b1, 4'd0, 32'd1000, OK,        32'd1000, 8'h00);
        issue(1'b1, 4'd1, 32'd20,   OK,        32'd20,   8'h00);
        issue(1'b1, 4'd1, 32'd51,   ERR_RANGE, 32'd0,    8'h00);
        issue(1'b0, 4'd1, 32'd0,    OK,        32'd20,   8'h00);
        issue(1'b1, 4'd8, 32'd5,    ERR_ADDR,  32'd0,    8'h00);
        issue(1'b1, 4'd2, 32'd3,    ERR_RIGHTS,32'd0,    8'h00);
        rom_tbl[2].rights = PRM_RW;
        issue(1'b1, 4'd2, 32'd3,    OK,        32'd3,    8'h04);
        issue(1'b0, 4'd5, 32'd0,    ERR_RIGHTS,32'd0,    8'h00);
        issue(1'b1, 4'd5, 32'd9,    OK,        32'd9,    8'h00);
        issue(1'b1, 4'd6, 32'd9,    ERR_RANGE, 32'd0,    8'h00);
        issue(1'b1, 4'd6, 32'd10,   OK,        32'd10,   8'h00);
        issue(1'b1, 4'd6, 32'd20,   OK,        32'd20,   8'h00);
        issue(1'b1, 4'd6, 32'd21,   ERR_RANGE, 32'd0,    8'h00);
        issue(1'b0, 4'd8, 32'd0,    ERR_ADDR,  32'd0,    8'h00);

        // Back-pressure: response held while a competing request waits.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(1'b0, 4'd0, 32'd0, OK, 32'd1000, 8'h00);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 4'd3;
        req_val   = 32'd7;
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", N*VW'(rsp_valid), N*VW'(1));
            chk("hold_status", N*VW'(rsp_status), N*VW'(OK));
            chk("hold_val", N*VW'(rsp_val), N*VW'(1000));
            chk("hold_req_ready", N*VW'(req_ready), '0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_req_ready", N*VW'(req_ready), '0);
        push_exp(OK, 32'd7);
        exp_regs[3] = 32'd7;
        @(negedge clk);
        chk("post_rsp_req_ready", N*VW'(req_ready), N*VW'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp(4'd3, 8'h00);

        // Reset while an OK exec write sits in CHECK.
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 4'd4;
        req_val   = 32'd99;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < int'(N); i++) exp_regs[i] = '0;
        chk("mid_rst_req_ready", N*VW'(req_ready), N*VW'(1));
        chk("mid_rst_rsp_valid", N*VW'(rsp_valid), '0);
        chk("mid_rst_rsp_status", N*VW'(rsp_status), N*VW'(OK));
        chk("mid_rst_rsp_val", N*VW'(rsp_val), '0);
        chk("mid_rst_rom_addr", N*VW'(rom_addr), '0);
        chk("mid_rst_regs", prm_regs, '0);
        chk("mid_rst_exec", N*VW'(exec_pulse), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_rsp", N*VW'(rsp_valid), '0);
            chk("post_rst_no_exec", N*VW'(exec_pulse), '0);
            chk("post_rst_regs", prm_regs, '0);
        end

        issue(1'b0, 4'd4, 32'd0, OK, 32'd0, 8'h00);
        repeat (2) @(negedge clk);
        chk("scoreboard_empty", N*VW'(exp_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
